// File: rtl/cache_def.sv
// Shared cache-port definitions used by the CPU-side adapters and the cache itself.
package cache_def;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
    logic        rw;
    logic        valid;
  } cpu_req_type;

  typedef struct packed {
    logic [31:0] data;
    logic        ready;
  } cpu_result_type;

endpackage

// File: rtl/mem_req_pkg.sv
// Types for the MEM-stage cache adapter: op codes, error codes, FSM states, lane modes.
package mem_req_pkg;

  typedef enum logic [2:0] {
    OP_LW  = 3'd0,
    OP_SW  = 3'd1,
    OP_LB  = 3'd2,
    OP_LBU = 3'd3,
    OP_SB  = 3'd4
  } mem_op_e;

  typedef enum logic [1:0] {
    ERR_NONE     = 2'd0,
    ERR_MISALIGN = 2'd1,
    ERR_ILLEGAL  = 2'd2,
    ERR_TIMEOUT  = 2'd3
  } err_e;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_REQ    = 3'd1,
    S_RMW_RD = 3'd2,
    S_RMW_WR = 3'd3,
    S_DONE   = 3'd4
  } state_e;

  typedef enum logic [1:0] {
    LANE_EXT_S = 2'd0,
    LANE_EXT_U = 2'd1,
    LANE_MERGE = 2'd2
  } lane_mode_e;

endpackage

// File: rtl/mem_req_adapter_byte_lane.sv
// Little-endian byte lane helper: extracts a lane (sign/zero extended) or merges a byte into it.
module byte_lane
  import mem_req_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  lane,
  input  logic [7:0]  byte_val,
  input  lane_mode_e  mode,
  output logic [31:0] result
);

  logic [7:0] sel;

  assign sel = word[{lane, 3'b000} +: 8];

  always_comb begin
    result = word;
    case (mode)
      LANE_EXT_S: result = {{24{sel[7]}}, sel};
      LANE_EXT_U: result = {24'h0, sel};
      LANE_MERGE: result[{lane, 3'b000} +: 8] = byte_val;
      default:    result = '0;
    endcase
  end

endmodule

// File: rtl/mem_req_adapter.sv
// MEM-stage front end for the cache: holds one load/store until the cache replies,
// stalls the pipeline meanwhile, and does byte stores as read-modify-write.
module mem_req_adapter
  import cache_def::*;
  import mem_req_pkg::*;
#(
  parameter int WAIT_LIMIT = 4096
) (
  input  logic           sys_clk,
  input  logic           rstn,
  input  logic           mem_valid,
  input  logic [2:0]     mem_op,
  input  logic [31:0]    mem_addr,
  input  logic [31:0]    mem_wdata,
  output logic           stall,
  output logic           done,
  output logic [31:0]    rdata,
  output logic [1:0]     err,
  output cpu_req_type    cpu_req,
  input  cpu_result_type cpu_res
);

  localparam int CW = ($clog2(WAIT_LIMIT) > 0) ? $clog2(WAIT_LIMIT) : 1;
  localparam logic [CW-1:0] LIMIT_M1 = CW'(WAIT_LIMIT - 1);

  state_e        state, state_next;
  logic [CW-1:0] wait_cnt;
  mem_op_e       op_q;
  logic [1:0]    lane_q;
  logic [7:0]    wbyte_q;

  cpu_req_type   req_next;
  logic [31:0]   rdata_next;
  err_e          err_next;
  logic          done_next;

  logic          ready_ok, waiting, timeout, illegal_op, misaligned;
  lane_mode_e    lane_mode;
  logic [31:0]   lane_out;

  // A reply only counts while a request is actually on the port.
  assign ready_ok   = cpu_res.ready & cpu_req.valid;
  assign waiting    = (state == S_REQ) || (state == S_RMW_RD) || (state == S_RMW_WR);
  assign timeout    = waiting && (wait_cnt == LIMIT_M1) && !ready_ok;
  assign illegal_op = (mem_op > 3'd4);
  assign misaligned = ((mem_op == OP_LW) || (mem_op == OP_SW)) && (mem_addr[1:0] != 2'b00);

  assign lane_mode = (state == S_RMW_RD) ? LANE_MERGE :
                     (op_q == OP_LBU)    ? LANE_EXT_U : LANE_EXT_S;

  byte_lane u_byte_lane (
    .word     (cpu_res.data),
    .lane     (lane_q),
    .byte_val (wbyte_q),
    .mode     (lane_mode),
    .result   (lane_out)
  );

  always_ff @(posedge sys_clk or negedge rstn) begin
    if (!rstn) state <= S_IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE: begin
        if (mem_valid) begin
          if (illegal_op || misaligned) state_next = S_DONE;
          else if (mem_op == OP_SB)     state_next = S_RMW_RD;
          else                          state_next = S_REQ;
        end
      end
      S_REQ:    if (ready_ok || timeout) state_next = S_DONE;
      S_RMW_RD: begin
        if (ready_ok)     state_next = S_RMW_WR;
        else if (timeout) state_next = S_DONE;
      end
      S_RMW_WR: if (ready_ok || timeout) state_next = S_DONE;
      S_DONE:   state_next = S_IDLE;
      default:  state_next = S_IDLE;
    endcase
  end

  // Next values of the registered cache request and result outputs.
  always_comb begin
    stall      = mem_valid && (state != S_DONE);
    req_next   = cpu_req;
    rdata_next = '0;
    err_next   = ERR_NONE;
    done_next  = (state_next == S_DONE);
    case (state)
      S_IDLE: begin
        if (mem_valid) begin
          if (illegal_op) begin
            err_next = ERR_ILLEGAL;
          end else if (misaligned) begin
            err_next = ERR_MISALIGN;
          end else begin
            req_next.valid = 1'b1;
            req_next.addr  = {mem_addr[31:2], 2'b00};
            req_next.rw    = (mem_op == OP_SW);
            req_next.data  = mem_wdata;
          end
        end
      end
      S_REQ: begin
        if (ready_ok) begin
          req_next.valid = 1'b0;
          case (op_q)
            OP_LW:          rdata_next = cpu_res.data;
            OP_LB, OP_LBU:  rdata_next = lane_out;
            default:        rdata_next = '0;
          endcase
        end else if (timeout) begin
          req_next.valid = 1'b0;
          err_next       = ERR_TIMEOUT;
        end
      end
      S_RMW_RD: begin
        if (ready_ok) begin
          req_next.valid = 1'b0;
          req_next.rw    = 1'b1;
          req_next.data  = lane_out;
        end else if (timeout) begin
          req_next.valid = 1'b0;
          err_next       = ERR_TIMEOUT;
        end
      end
      S_RMW_WR: begin
        // First cycle here has valid low; it rises on the next edge.
        if (ready_ok) begin
          req_next.valid = 1'b0;
        end else if (timeout) begin
          req_next.valid = 1'b0;
          err_next       = ERR_TIMEOUT;
        end else begin
          req_next.valid = 1'b1;
        end
      end
      default: req_next.valid = 1'b0;
    endcase
  end

  always_ff @(posedge sys_clk or negedge rstn) begin
    if (!rstn) begin
      cpu_req <= '0;
      rdata   <= '0;
      err     <= ERR_NONE;
      done    <= 1'b0;
      op_q    <= OP_LW;
      lane_q  <= 2'b00;
      wbyte_q <= 8'h00;
    end else begin
      cpu_req <= req_next;
      rdata   <= rdata_next;
      err     <= err_next;
      done    <= done_next;
      if ((state == S_IDLE) && ((state_next == S_REQ) || (state_next == S_RMW_RD))) begin
        op_q    <= mem_op_e'(mem_op);
        lane_q  <= mem_addr[1:0];
        wbyte_q <= mem_wdata[7:0];
      end
    end
  end

  always_ff @(posedge sys_clk or negedge rstn) begin
    if (!rstn)                    wait_cnt <= '0;
    else if (state_next != state) wait_cnt <= '0;
    else if (waiting)             wait_cnt <= wait_cnt + CW'(1);
    else                          wait_cnt <= '0;
  end

endmodule

// File: doc/mem_req_adapter.md
# mem_req_adapter

Pipeline-side front end for the set-associative cache. It accepts one load or store per transaction from the CPU MEM stage and drives `cpu_to_cache_request` (`cpu_req_type`). It holds the request until the cache answers through `cpu_res` (`cpu_result_type`), stalls the pipeline meanwhile, and returns aligned, extended load data. Byte stores are done as read-modify-write, because the cache port is word-only.

## Interface
- `WAIT_LIMIT`, default 4096: maximum cycles to wait for `cpu_res.ready` before aborting with a timeout error.
- `sys_clk`  in  1  sole clock; all state updates on rising edge.
- `rstn`  in  1  asynchronous, active-low reset.
- `mem_valid`  in  1  pipeline presents an access.
- `mem_op`  in  3  0=LW, 1=SW, 2=LB, 3=LBU, 4=SB, 5–7 illegal.
- `mem_addr`  in  32  byte address.
- `mem_wdata`  in  32  store data; SB uses bits [7:0].
- `stall`  out  1  pipeline must hold MEM-stage inputs.
- `done`  out  1  one-cycle completion pulse.
- `rdata`  out  32  load result, valid while `done`=1.
- `err`  out  2  error code, valid while `done`=1: 0 none, 1 misaligned, 2 illegal op, 3 timeout.
- `cpu_req`  out  `cpu_req_type`  request to cache: `addr[31:0]`, `data[31:0]`, `rw` (1=write), `valid`.
- `cpu_res`  in  `cpu_result_type`  cache reply: `data[31:0]`, `ready` (one-cycle pulse).

## Operation
States: IDLE, REQ, RMW_RD, RMW_WR, DONE.

IDLE:
- Accepts when `mem_valid`=1.
- LW/SW with `addr[1:0]`≠0 → DONE with `err`=1.
- Op 5–7 → DONE with `err`=2.
- LW/LB/LBU/SW → REQ.
- SB → RMW_RD.

REQ:
- `cpu_req.valid`=1, `addr`=`{mem_addr[31:2],2'b00}`, `rw` per op, `data`=`mem_wdata`.
- On `ready` → DONE.

RMW_RD:
- Read of the aligned word.
- On `ready`: merge `mem_wdata[7:0]` into lane `addr[1:0]` (lane k = bits [8k+7:8k], little-endian), → RMW_WR.

RMW_WR:
- Write of the merged word.
- On `ready` → DONE.

DONE:
- One cycle: `done`=1, → IDLE.
- `mem_valid` is not accepted in DONE.

Load data:
- LW: `rdata` = `cpu_res.data`.
- LB: `rdata` = selected lane, sign-extended.
- LBU: `rdata` = selected lane, zero-extended.
- Stores and errors: `rdata`=0.

Timeout:
- A wait counter increments in REQ/RMW_RD/RMW_WR and clears on every state change.
- When it reaches `WAIT_LIMIT`-1 without `ready` → DONE with `err`=3.
- `ready` in the same cycle as the limit: `ready` wins, no error.

Ignored events: `cpu_res.ready` in IDLE or DONE is ignored (late or stale reply).

## Timing
Reset values:
- State: IDLE.
- `cpu_req`: all fields 0.
- `rdata`=0, `done`=0, `err`=0.
- Counter: 0.

Outputs:
- `cpu_req` is registered: valid rises the cycle after acceptance.
- `addr`/`data`/`rw` stay stable while valid=1.
- valid drops the cycle after `ready` is sampled.
- In RMW, valid stays low for exactly one cycle between the read and the write.
- `stall` = `mem_valid` & (state≠DONE); it is combinational, so it is high in the accept cycle.
- `rdata`/`err` are registered at the transition into DONE.

Latency, from acceptance to `done`, with cache hit latency L (ready L cycles after valid rises):
- Word access or byte load: L+2.
- SB: 2L+4.
- Error path: 1.

Reset mid-transaction:
- `cpu_req.valid` drops immediately and the transaction is abandoned.
- No `done` is produced.

## Structure
- Package `mem_req_pkg` holds `mem_op_e`, `err_e` and `state_e`.
- `cpu_req_type`/`cpu_result_type` stay in the existing cache definitions package and are imported.
- One combinational sub-module, `byte_lane`:
  - Inputs: word, lane index, byte, mode (extract-signed / extract-unsigned / merge).
  - Output: 32-bit result.
  - Used for both load extraction and the SB merge.

## Test plan
- LW 0x0000_0010, cache ready 3 cycles after valid, data 0xDEADBEEF → `rdata`=0xDEADBEEF, `err`=0, `done` 5 cycles after accept, `stall` high until then.
- LB 0x0000_0013, word 0x80112233 → `rdata`=0xFFFFFF80; LBU same address → 0x00000080.
- SB 0x0000_0021, wdata 0xAB, word read 0x11223344 → second request: `rw`=1, `addr`=0x20, `data`=0x1122AB44; one idle-valid cycle between read and write.
- SW 0x0000_0006 → no `cpu_req.valid` ever, `done` next cycle, `err`=1; `mem_op`=6 → `err`=2.
- `WAIT_LIMIT`=8, cache never ready → `done` with `err`=3 after 8 waiting cycles; a `ready` arriving later in IDLE causes no state change.
- `rstn` asserted while in RMW_WR → `cpu_req.valid`=0 immediately; after release, state is IDLE and the next LW completes normally.
